cdd_link: RTL and testbench

- Parametrised successor to the CD-drive MCU emulation: a Sony CDD-style nibble link between the host CD interface (HOCK/CDCK) and the drive model.
- Fires a periodic IRQ, then runs one status frame (CDD→host) and one command frame (host→CDD).
- Adds over the previous block: configurable frame length/rate, auto-generated status checksum, command checksum verification, handshake watchdog, enable gating, and a decoded command output for the drive model.

---
 rtl/cdd_link_if.sv | 13 +
 rtl/cdd_link.sv | 177 +++++++++++++++++
 tb/tb_cdd_link.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cdd_link_if.sv
// cdd_link_if: host <-> CDD nibble link bundle (strobes, data each way, frame IRQ).
// master = host side: drives HOCK, CDD_DIN; reads CDCK, CDD_DOUT, CD_nIRQ.
// slave  = CDD side: drives CDCK, CDD_DOUT, CD_nIRQ; HOCK is asynchronous to the CDD clock.
interface cdd_link_if;
    logic       HOCK;
    logic [3:0] CDD_DIN;
    logic       CDCK;
    logic [3:0] CDD_DOUT;
    logic       CD_nIRQ;

    modport master (output HOCK, output CDD_DIN, input CDCK, input CDD_DOUT, input CD_nIRQ);
    modport slave  (input HOCK, input CDD_DIN, output CDCK, output CDD_DOUT, output CD_nIRQ);
endinterface

// File: rtl/cdd_link.sv
// cdd_link: CDD-side nibble link; periodic IRQ, then status frame out, command frame in.
// Latency: one MCU tick per FSM step; HOCK edges seen 2 sync cycles plus up to one tick late.
// Backpressure: fully host-paced via HOCK; a stalled host is aborted by the handshake watchdog.
// Ports: nRESET/CLK_12M, ENABLE, link (slave), STATUS_IN, CMD_OUT and the event pulses.
module cdd_link #(
    parameter int CLK_DIV       = 48,
    parameter int IRQ_PERIOD    = 3906,
    parameter int FRAME_NIBBLES = 10,
    parameter int HS_TIMEOUT    = 2048
) (
    input  logic                           nRESET,
    input  logic                           CLK_12M,
    input  logic                           ENABLE,
    cdd_link_if.slave                      link,
    input  logic [4*(FRAME_NIBBLES-1)-1:0] STATUS_IN,
    output logic [4*FRAME_NIBBLES-1:0]     CMD_OUT,
    output logic                           CMD_VALID,
    output logic                           CMD_CSUM_ERR,
    output logic                           TIMEOUT,
    output logic                           IRQ_MISSED
);
    localparam int N  = FRAME_NIBBLES;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int IW = $clog2(IRQ_PERIOD + 1);
    localparam int WW = $clog2(HS_TIMEOUT + 1);
    localparam int XW = $clog2(N + 1);
    localparam int SW = 4 + $clog2(N);

    typedef enum logic [2:0] {IDLE, IRQ_WAIT, TX_PUT, TX_HI, TX_LO, RX_HI, RX_LO} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]  div_cnt;
    logic [IW-1:0]  irq_cnt;
    logic [WW-1:0]  wd_cnt;
    logic [XW-1:0]  idx, idx_nxt;
    logic           hs_meta, hs, hs_prev;
    logic           tick, rise, fall, irq_wrap, wd_expire;
    logic [4*N-1:0] tx_buf, tx_nxt, rx_buf, rx_nxt, cmd_nxt;
    logic           cdck, cdck_nxt, nirq, nirq_nxt;
    logic [3:0]     dout, dout_nxt;

    // Frame checksum: inverted low nibble of the sum of the payload nibbles.
    function automatic logic [3:0] csum(input logic [4*(N-1)-1:0] v);
        logic [SW-1:0] s;
        s = '0;
        for (int k = 0; k < N - 1; k++) s = s + SW'(v[4*k +: 4]);
        return ~s[3:0];
    endfunction

    assign tick      = (div_cnt == DW'(CLK_DIV - 1));
    assign rise      = tick & ~hs_prev & hs;
    assign fall      = tick & hs_prev & ~hs;
    assign irq_wrap  = tick & (irq_cnt == IW'(IRQ_PERIOD - 1));
    assign wd_expire = tick & (state != IDLE) & (wd_cnt == WW'(HS_TIMEOUT - 1));
    // Decided on the pre-tick state, so a frame that ends or aborts on the wrap tick still misses it.
    assign IRQ_MISSED = irq_wrap & ENABLE & (state != IDLE);

    assign link.CDCK     = cdck;
    assign link.CDD_DOUT = dout;
    assign link.CD_nIRQ  = nirq;

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        cdck_nxt     = cdck;
        dout_nxt     = dout;
        nirq_nxt     = nirq;
        tx_nxt       = tx_buf;
        rx_nxt       = rx_buf;
        cmd_nxt      = CMD_OUT;
        CMD_VALID    = 1'b0;
        CMD_CSUM_ERR = 1'b0;
        TIMEOUT      = 1'b0;
        if (wd_expire) begin
            // Abort wins over any handshake progress on the same tick.
            TIMEOUT   = 1'b1;
            state_nxt = IDLE;
            cdck_nxt  = 1'b0;
            nirq_nxt  = 1'b1;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    cdck_nxt = 1'b0;
                    if (irq_wrap && ENABLE) begin
                        tx_nxt    = {csum(STATUS_IN), STATUS_IN};
                        nirq_nxt  = 1'b0;
                        state_nxt = IRQ_WAIT;
                    end
                end
                IRQ_WAIT: if (!hs) begin
                    nirq_nxt  = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = TX_PUT;
                end
                TX_PUT: begin
                    dout_nxt  = tx_buf[4*int'(idx) +: 4];
                    cdck_nxt  = 1'b0;
                    state_nxt = TX_HI;
                end
                TX_HI: if (rise) begin
                    cdck_nxt = 1'b1;
                    if (idx == XW'(N - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = RX_HI;
                    end else begin
                        state_nxt = TX_LO;
                    end
                end
                TX_LO: if (fall) begin
                    idx_nxt   = idx + XW'(1);
                    state_nxt = TX_PUT;
                end
                RX_HI: if (rise) begin
                    rx_nxt[4*int'(idx) +: 4] = link.CDD_DIN;
                    cdck_nxt  = 1'b1;
                    idx_nxt   = idx + XW'(1);
                    state_nxt = RX_LO;
                end
                RX_LO: if (fall) begin
                    cdck_nxt = 1'b0;
                    if (idx == XW'(N)) begin
                        state_nxt = IDLE;
                        if (rx_buf[4*N-1 -: 4] == csum(rx_buf[4*(N-1)-1:0])) begin
                            cmd_nxt   = rx_buf;
                            CMD_VALID = 1'b1;
                        end else begin
                            CMD_CSUM_ERR = 1'b1;
                        end
                    end else begin
                        state_nxt = RX_HI;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            div_cnt <= '0;
            irq_cnt <= '0;
            wd_cnt  <= '0;
            idx     <= '0;
            hs_meta <= 1'b0;
            hs      <= 1'b0;
            hs_prev <= 1'b0;
            tx_buf  <= '0;
            rx_buf  <= '0;
            CMD_OUT <= '0;
            cdck    <= 1'b0;
            dout    <= 4'h0;
            nirq    <= 1'b1;
        end else begin
            hs_meta <= link.HOCK;
            hs      <= hs_meta;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            if (tick) begin
                hs_prev <= hs;
                irq_cnt <= irq_wrap ? '0 : irq_cnt + IW'(1);
                // Watchdog measures time spent in one non-idle state.
                wd_cnt  <= (state == IDLE || state_nxt != state) ? '0 : wd_cnt + WW'(1);
            end
            idx     <= idx_nxt;
            tx_buf  <= tx_nxt;
            rx_buf  <= rx_nxt;
            CMD_OUT <= cmd_nxt;
            cdck    <= cdck_nxt;
            dout    <= dout_nxt;
            nirq    <= nirq_nxt;
        end
    end
endmodule

// File: tb/tb_cdd_link.sv
`timescale 1ns/1ps
module tb_cdd_link;
    localparam int CLK_DIV    = 4;
    localparam int IRQ_PERIOD = 200;
    localparam int N          = 10;
    localparam int HS_TIMEOUT = 64;
    localparam int PER_CYC    = CLK_DIV * IRQ_PERIOD;
    localparam int STW        = 4 * (N - 1);
    localparam int CW         = 4 * N;
    localparam int HALF       = 16;

    logic           CLK_12M = 1'b0;
    logic           nRESET  = 1'b0;
    logic           ENABLE  = 1'b0;
    logic [STW-1:0] STATUS_IN = '0;
    logic [CW-1:0]  CMD_OUT;
    logic           CMD_VALID, CMD_CSUM_ERR, TIMEOUT, IRQ_MISSED;

    cdd_link_if link();

    cdd_link #(.CLK_DIV(CLK_DIV), .IRQ_PERIOD(IRQ_PERIOD), .FRAME_NIBBLES(N), .HS_TIMEOUT(HS_TIMEOUT)) dut (
        .nRESET(nRESET), .CLK_12M(CLK_12M), .ENABLE(ENABLE), .link(link),
        .STATUS_IN(STATUS_IN), .CMD_OUT(CMD_OUT), .CMD_VALID(CMD_VALID),
        .CMD_CSUM_ERR(CMD_CSUM_ERR), .TIMEOUT(TIMEOUT), .IRQ_MISSED(IRQ_MISSED)
    );

    always #5 CLK_12M = ~CLK_12M;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse / IRQ event monitor.
    int   n_valid = 0, n_err = 0, n_to = 0, n_miss = 0, n_irqfall = 0, n_wide = 0;
    logic p_valid = 0, p_err = 0, p_to = 0, p_miss = 0, p_nirq = 1;
    always @(negedge CLK_12M) begin
        n_valid   <= n_valid + (CMD_VALID ? 1 : 0);
        n_err     <= n_err + (CMD_CSUM_ERR ? 1 : 0);
        n_to      <= n_to + (TIMEOUT ? 1 : 0);
        n_miss    <= n_miss + (IRQ_MISSED ? 1 : 0);
        n_irqfall <= n_irqfall + ((p_nirq && !link.CD_nIRQ) ? 1 : 0);
        n_wide    <= n_wide + (((CMD_VALID && p_valid) || (CMD_CSUM_ERR && p_err) ||
                                (TIMEOUT && p_to) || (IRQ_MISSED && p_miss)) ? 1 : 0);
        p_valid <= CMD_VALID; p_err <= CMD_CSUM_ERR; p_to <= TIMEOUT; p_miss <= IRQ_MISSED;
        p_nirq  <= link.CD_nIRQ;
    end

    // Reference model: frame checksum by plain arithmetic.
    function automatic int nib_sum(input logic [CW-1:0] v, input int cnt);
        int s = 0;
        for (int k = 0; k < cnt; k++) s += int'(v[4*k +: 4]);
        return s;
    endfunction
    function automatic logic [3:0] exp_csum(input int s);
        return 4'(15 - (s % 16));
    endfunction

    typedef struct {
        logic [STW-1:0] status;
        logic [CW-1:0]  cmd;
        logic           exp_valid;
        logic [3:0]     exp_cs;
        int             mode;      // 0 normal, 1 host stall across IRQ slot, 2 ENABLE drop mid-frame
    } vec_t;
    vec_t vecs[8];
    logic [CW-1:0] cmd_model = '0;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLK_12M);
    endtask

    task automatic run_frame(input vec_t v, input int rst_after);
        int t, f0, v0, e0, to0, m0;
        logic [3:0] exp_nib;
        STATUS_IN = v.status;
        t = 0;
        while (link.CD_nIRQ !== 1'b0 && t < 1000) begin @(negedge CLK_12M); t++; end
        check("irq_assert", 64'(link.CD_nIRQ), 64'(0));
        if (link.CD_nIRQ !== 1'b0) return;
        v0 = n_valid; e0 = n_err; to0 = n_to; m0 = n_miss;
        STATUS_IN = STW'({$urandom(), $urandom()});   // must not affect the latched frame
        link.HOCK = 1'b0;
        wait_cyc(HALF);
        check("irq_ack_release", 64'(link.CD_nIRQ), 64'(1));
        f0 = n_irqfall;
        if (v.mode == 2) ENABLE = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_nib = (k == N - 1) ? v.exp_cs : v.status[4*k +: 4];
            check("tx_cdck_lo", 64'(link.CDCK), 64'(0));
            link.HOCK = 1'b1;
            wait_cyc(HALF);
            check("tx_cdck_hi", 64'(link.CDCK), 64'(1));
            check("tx_nibble", 64'(link.CDD_DOUT), 64'(exp_nib));
            link.HOCK = 1'b0;
            wait_cyc(HALF);
            if (v.mode == 1 && k == 4) wait_cyc(200);
        end
        for (int k = 0; k < N; k++) begin
            link.CDD_DIN = v.cmd[4*k +: 4];
            link.HOCK = 1'b1;
            wait_cyc(HALF);
            check("rx_cdck_hi", 64'(link.CDCK), 64'(1));
            link.HOCK = 1'b0;
            wait_cyc(HALF);
            check("rx_cdck_lo", 64'(link.CDCK), 64'(0));
            if (k + 1 == rst_after) begin
                nRESET = 1'b0;
                #1;
                check("rst_cdck", 64'(link.CDCK), 64'(0));
                check("rst_dout", 64'(link.CDD_DOUT), 64'(0));
                check("rst_nirq", 64'(link.CD_nIRQ), 64'(1));
                check("rst_cmd_out", 64'(CMD_OUT), 64'(0));
                check("rst_pulses", 64'({CMD_VALID, CMD_CSUM_ERR, TIMEOUT, IRQ_MISSED}), 64'(0));
                cmd_model = '0;
                wait_cyc(3);
                nRESET = 1'b1;
                link.HOCK = 1'b1;
                wait_cyc(300);
                check("rst_no_cmd_pulse", 64'((n_valid - v0) + (n_err - e0)), 64'(0));
                return;
            end
        end
        check("cmd_valid_pulse", 64'(n_valid - v0), 64'(v.exp_valid));
        check("csum_err_pulse", 64'(n_err - e0), 64'(!v.exp_valid));
        check("no_timeout", 64'(n_to - to0), 64'(0));
        check("irq_missed", 64'(n_miss - m0), 64'((v.mode == 1) ? 1 : 0));
        check("irq_held_high", 64'(n_irqfall - f0), 64'(0));
        if (v.exp_valid) cmd_model = v.cmd;
        check("cmd_out", 64'(CMD_OUT), 64'(cmd_model));
        link.HOCK = 1'b1;
        ENABLE = 1'b1;
    endtask

    initial begin
        int n, f0, m0;
        logic [CW-1:0] c;
        int s;
        // Directed rows: status 0..8 -> checksum 0xB; good and bad command frames.
        vecs[0] = '{status: 36'h876543210, cmd: 40'hE000000001, exp_valid: 1'b1, exp_cs: 4'hB, mode: 0};
        vecs[1] = '{status: 36'h876543210, cmd: 40'h3000000001, exp_valid: 1'b0, exp_cs: 4'hB, mode: 0};
        for (int i = 2; i < 8; i++) begin
            vecs[i].status = STW'({$urandom(), $urandom()});
            vecs[i].exp_cs = exp_csum(nib_sum(CW'(vecs[i].status), N - 1));
            c = CW'({$urandom(), $urandom()});
            s = nib_sum(c, N - 1);
            if ($urandom_range(0, 1) == 1) c[4*(N-1) +: 4] = exp_csum(s);
            vecs[i].cmd       = c;
            vecs[i].exp_valid = (c[4*(N-1) +: 4] == exp_csum(s));
            vecs[i].mode      = (i == 3) ? 1 : ((i == 5) ? 2 : 0);
        end

        link.HOCK = 1'b1;
        link.CDD_DIN = 4'h0;
        ENABLE = 1'b1;
        wait_cyc(5);
        check("reset_cdck", 64'(link.CDCK), 64'(0));
        check("reset_dout", 64'(link.CDD_DOUT), 64'(0));
        check("reset_nirq", 64'(link.CD_nIRQ), 64'(1));
        check("reset_cmd_out", 64'(CMD_OUT), 64'(0));
        check("reset_pulses", 64'({CMD_VALID, CMD_CSUM_ERR, TIMEOUT, IRQ_MISSED}), 64'(0));
        nRESET = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i], -1);

        // Watchdog: host never acks.
        STATUS_IN = vecs[2].status;
        m0 = n_miss;
        n = 0;
        while (link.CD_nIRQ !== 1'b0 && n < 1000) begin @(negedge CLK_12M); n++; end
        check("wd_irq_assert", 64'(link.CD_nIRQ), 64'(0));
        n = 0;
        while (TIMEOUT !== 1'b1 && n < 400) begin @(negedge CLK_12M); n++; end
        check("wd_timeout_cycles", 64'(n), 64'(HS_TIMEOUT * CLK_DIV - 1));
        @(negedge CLK_12M);
        check("wd_irq_release", 64'(link.CD_nIRQ), 64'(1));
        check("wd_cdck", 64'(link.CDCK), 64'(0));
        n = 1;
        while (link.CD_nIRQ !== 1'b0 && n < 700) begin @(negedge CLK_12M); n++; end
        check("wd_next_irq_cycles", 64'(n), 64'(PER_CYC - (HS_TIMEOUT * CLK_DIV - 1)));
        check("wd_no_miss", 64'(n_miss - m0), 64'(0));
        run_frame(vecs[2], -1);

        // ENABLE low: no IRQs, no misses over 3 periods.
        ENABLE = 1'b0;
        f0 = n_irqfall; m0 = n_miss;
        wait_cyc(3 * PER_CYC);
        check("disabled_no_irq", 64'(n_irqfall - f0), 64'(0));
        check("disabled_no_miss", 64'(n_miss - m0), 64'(0));
        ENABLE = 1'b1;

        // Reset after 5 command nibbles, then a clean frame.
        run_frame(vecs[0], 5);
        run_frame(vecs[0], -1);

        check("pulse_width", 64'(n_wide), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
